// File: rtl/de10_lite_alu_wrapper.sv
// DE10-Lite board top: 4-bit ALU on the switches, Key1 steps ADD/SUB/AND/OR,
// operands, mode and result shown on active-low seven-segment displays.
module de10_lite_alu_wrapper (
   input  logic       clk_50MHz,
   input  logic       Key0,
   input  logic [3:0] switchSetA,
   input  logic [3:0] switchSetB,
   input  logic       carryInSwitch,
   input  logic       Key1,
   output logic [3:0] modeLEDs,
   output logic [7:0] Hex0,
   output logic [7:0] Hex1,
   output logic [7:0] Hex2,
   output logic [7:0] Hex3,
   output logic [7:0] Hex4
);

   typedef enum logic [1:0] {
      MODE_ADD = 2'd0,
      MODE_SUB = 2'd1,
      MODE_AND = 2'd2,
      MODE_OR  = 2'd3
   } mode_t;

   mode_t      mode;
   logic       key1_meta;
   logic       key1_sync;
   logic       key1_prev;
   logic       key1_armed;
   logic [1:0] sync_fill;
   logic       key1_fall;
   logic [4:0] result;

   // {dp,g,f,e,d,c,b,a}, active-low, decimal point kept dark
   function automatic logic [7:0] seg7(input logic [3:0] digit);
      case (digit)
         4'h0: seg7 = 8'hC0;
         4'h1: seg7 = 8'hF9;
         4'h2: seg7 = 8'hA4;
         4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;
         4'h5: seg7 = 8'h92;
         4'h6: seg7 = 8'h82;
         4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;
         4'h9: seg7 = 8'h90;
         4'hA: seg7 = 8'h88;
         4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;
         4'hD: seg7 = 8'hA1;
         4'hE: seg7 = 8'h86;
         default: seg7 = 8'h8E;
      endcase
   endfunction

   // A press only counts once the synchronizer has seen the key released
   // after reset, so a key held low through reset release never steps.
   assign key1_fall = key1_armed & key1_prev & ~key1_sync;

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      result = 5'd0;
      case (mode)
         MODE_ADD: result = {1'b0, switchSetA} + {1'b0, switchSetB} + {4'd0, carryInSwitch};
         MODE_SUB: result = {1'b0, switchSetA} - {1'b0, switchSetB} - {4'd0, carryInSwitch};
         MODE_AND: result = {1'b0, switchSetA & switchSetB};
         default:  result = {1'b0, switchSetA | switchSetB};
      endcase
   end

   // NOTE: every register here uses <= so all of them sample pre-edge values,
   // which is what makes the synchronizer chain behave as a shift register.
   always_ff @(posedge clk_50MHz) begin
      if (!Key0) begin
         mode       <= MODE_ADD;
         modeLEDs   <= 4'b0001;
         key1_meta  <= 1'b1;
         key1_sync  <= 1'b1;
         key1_prev  <= 1'b1;
         key1_armed <= 1'b0;
         sync_fill  <= 2'b00;
         Hex0       <= 8'hFF;
         Hex1       <= 8'hFF;
         Hex2       <= 8'hFF;
         Hex3       <= 8'hFF;
         Hex4       <= 8'hFF;
      end else begin
         key1_meta <= Key1;
         key1_sync <= key1_meta;
         key1_prev <= key1_sync;
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && key1_sync)
            key1_armed <= 1'b1;
         if (key1_fall)
            mode <= mode_t'(mode + 2'd1);
         modeLEDs <= 4'b0001 << mode;
         Hex0     <= seg7(result[3:0]);
         Hex1     <= seg7({3'b000, result[4]});
         Hex2     <= seg7({2'b00, mode});
         Hex3     <= seg7(switchSetB);
         Hex4     <= seg7(switchSetA);
      end
   end

endmodule

// File: tb/tb_de10_lite_alu_wrapper.sv
// Self-checking bench for de10_lite_alu_wrapper: reset values, directed
// vector table, Key1 latency/hold/reset corners and randomized operands.
module tb_de10_lite_alu_wrapper;

   logic       clk_50MHz = 1'b0;
   logic       Key0 = 1'b0;
   logic [3:0] switchSetA = 4'd0;
   logic [3:0] switchSetB = 4'd0;
   logic       carryInSwitch = 1'b0;
   logic       Key1 = 1'b1;
   logic [3:0] modeLEDs;
   logic [7:0] Hex0, Hex1, Hex2, Hex3, Hex4;

   int checks = 0;
   int failures = 0;
   int tb_mode = 0;

   localparam logic [7:0] GLYPH [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   typedef struct {
      int         mode;
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] exp_leds;
      logic [7:0] exp_hex0;
      logic [7:0] exp_hex1;
   } vec_t;

   vec_t vecs [7];

   de10_lite_alu_wrapper dut (
      .clk_50MHz    (clk_50MHz),
      .Key0         (Key0),
      .switchSetA   (switchSetA),
      .switchSetB   (switchSetB),
      .carryInSwitch(carryInSwitch),
      .Key1         (Key1),
      .modeLEDs     (modeLEDs),
      .Hex0         (Hex0),
      .Hex1         (Hex1),
      .Hex2         (Hex2),
      .Hex3         (Hex3),
      .Hex4         (Hex4)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk_50MHz);
      #1;
   endtask

   // Reference ALU from the arithmetic rules: 5-bit result.
   function automatic int ref_result(input int m, input int a, input int b, input int c);
      int r;
      case (m)
         0: r = a + b + c;
         1: r = ((a - b - c) & 15) + ((a < b + c) ? 16 : 0);
         2: r = a & b;
         default: r = a | b;
      endcase
      return r;
   endfunction

   task automatic check_all(input string tag);
      int r;
      r = ref_result(tb_mode, int'(switchSetA), int'(switchSetB), int'(carryInSwitch));
      check({tag, " leds"}, {4'd0, modeLEDs}, 8'(1 << tb_mode));
      check({tag, " hex0"}, Hex0, GLYPH[r & 15]);
      check({tag, " hex1"}, Hex1, GLYPH[r >> 4]);
      check({tag, " hex2"}, Hex2, GLYPH[tb_mode]);
      check({tag, " hex3"}, Hex3, GLYPH[switchSetB]);
      check({tag, " hex4"}, Hex4, GLYPH[switchSetA]);
   endtask

   // 100 ns low, 100 ns high at 50 MHz
   task automatic press();
      Key1 = 1'b0;
      repeat (5) step_clk();
      Key1 = 1'b1;
      repeat (5) step_clk();
      tb_mode = (tb_mode + 1) % 4;
   endtask

   task automatic goto_mode(input int m);
      for (int i = 0; i < 4 && tb_mode != m; i++) press();
   endtask

   initial begin
      vecs[0] = '{0, 4'h3, 4'h1, 1'b0, 4'b0001, 8'h99, 8'hC0};
      vecs[1] = '{1, 4'h3, 4'h1, 1'b0, 4'b0010, 8'hA4, 8'hC0};
      vecs[2] = '{2, 4'h3, 4'h1, 1'b0, 4'b0100, 8'hF9, 8'hC0};
      vecs[3] = '{3, 4'h3, 4'h1, 1'b0, 4'b1000, 8'hB0, 8'hC0};
      vecs[4] = '{0, 4'hF, 4'hF, 1'b1, 4'b0001, 8'h8E, 8'hF9};
      vecs[5] = '{1, 4'h1, 4'h3, 1'b0, 4'b0010, 8'h86, 8'hF9};
      vecs[6] = '{1, 4'h5, 4'h2, 1'b1, 4'b0010, 8'hA4, 8'hC0};

      // Reset values
      switchSetA = 4'h3;
      switchSetB = 4'h1;
      Key0 = 1'b0;
      repeat (3) step_clk();
      check("rst leds", {4'd0, modeLEDs}, 8'h01);
      check("rst hex0", Hex0, 8'hFF);
      check("rst hex1", Hex1, 8'hFF);
      check("rst hex2", Hex2, 8'hFF);
      check("rst hex3", Hex3, 8'hFF);
      check("rst hex4", Hex4, 8'hFF);

      // First cycle after release loads live values
      Key0 = 1'b1;
      step_clk();
      check("rel hex4", Hex4, 8'hB0);
      check("rel hex3", Hex3, 8'hF9);
      check("rel hex2", Hex2, 8'hC0);
      check("rel hex1", Hex1, 8'hC0);
      check("rel hex0", Hex0, 8'h99);
      repeat (3) step_clk();

      // Directed vector table
      foreach (vecs[i]) begin
         goto_mode(vecs[i].mode);
         switchSetA = vecs[i].a;
         switchSetB = vecs[i].b;
         carryInSwitch = vecs[i].cin;
         step_clk();
         check($sformatf("vec%0d leds", i), {4'd0, modeLEDs}, {4'd0, vecs[i].exp_leds});
         check($sformatf("vec%0d hex0", i), Hex0, vecs[i].exp_hex0);
         check($sformatf("vec%0d hex1", i), Hex1, vecs[i].exp_hex1);
         check($sformatf("vec%0d hex2", i), Hex2, GLYPH[vecs[i].mode]);
         check_all($sformatf("vec%0d", i));
      end

      // Key1 latency: first sampled at edge k, outputs change at edge k+3
      goto_mode(0);
      Key1 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step_clk();
         check($sformatf("lat edge%0d leds", i), {4'd0, modeLEDs}, 8'h01);
      end
      step_clk();
      check("lat edge4 leds", {4'd0, modeLEDs}, 8'h02);
      check("lat edge4 hex2", Hex2, GLYPH[1]);
      tb_mode = 1;
      Key1 = 1'b1;
      repeat (5) step_clk();

      // Held key from ADD: exactly one step, release adds none
      goto_mode(0);
      Key1 = 1'b0;
      repeat (50) step_clk();
      check("held leds", {4'd0, modeLEDs}, 8'h02);
      Key1 = 1'b1;
      repeat (10) step_clk();
      check("held release leds", {4'd0, modeLEDs}, 8'h02);
      tb_mode = 1;

      // Reset mid-operation with Key1 low, Key1 held across release
      goto_mode(3);
      Key1 = 1'b0;
      Key0 = 1'b0;
      step_clk();
      check("midrst leds", {4'd0, modeLEDs}, 8'h01);
      check("midrst hex0", Hex0, 8'hFF);
      check("midrst hex2", Hex2, 8'hFF);
      Key0 = 1'b1;
      tb_mode = 0;
      repeat (10) step_clk();
      check("held-through-rst leds", {4'd0, modeLEDs}, 8'h01);
      check_all("held-through-rst");
      Key1 = 1'b1;
      repeat (5) step_clk();
      check("after-rst release leds", {4'd0, modeLEDs}, 8'h01);
      press();
      check("after-rst press leds", {4'd0, modeLEDs}, 8'h02);

      // Randomized operands and mode steps against the reference model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(3) == 0) press();
         switchSetA = 4'($urandom_range(15));
         switchSetB = 4'($urandom_range(15));
         carryInSwitch = 1'($urandom_range(1));
         step_clk();
         check_all($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
